// File: rtl/sm_config_loader.sv
// Serial configuration loader for the switch-matrix routing tile: sync hunt, frame shift-in,
// entry range check and atomic commit. Optional CRC-8 frame check enabled by CFG_CRC_EN.
module sm_config_loader #(
  parameter int unsigned N_TB    = 5,
  parameter int unsigned N_LR    = 4,
  parameter int unsigned ENTRY_W = 6,
  parameter logic [7:0]  SYNC    = 8'hA5,
  localparam int unsigned N_ENT  = 2 * N_TB + 2 * N_LR,
  localparam int unsigned PAY_W  = N_ENT * ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  input  logic             cfg_abort,
  output logic [PAY_W-1:0] cfg_out,
  output logic             cfg_commit,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic [1:0]       err_code
);

  localparam int unsigned CNT_W = $clog2(PAY_W);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
`ifdef CFG_CRC_EN
    StCrc,
`endif
    StCheck
  } state_e;

  state_e             state_q;
  logic [7:0]         win_q;
  logic [PAY_W-1:0]   shadow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               all_valid;

`ifdef CFG_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_rx_q;
  logic [2:0] crc_cnt_q;
  logic [7:0] crc_nxt;

  // Serial CRC-8, poly 0x07, one payload bit per step
  assign crc_nxt = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ cfg_bit}} & 8'h07);
`endif

  assign cfg_ready = (state_q != StCheck);
  assign cfg_busy  = (state_q != StIdle);
  assign accept    = cfg_valid && cfg_ready;

  // Entry: [5:3] source index, [2:0] source side (0 = any, 1/3 top/bottom, 2/4 left/right)
  always_comb begin
    logic [2:0] idx;
    logic [2:0] side;
    all_valid = 1'b1;
    for (int k = 0; k < int'(N_ENT); k++) begin
      idx  = shadow_q[k * ENTRY_W + 3 +: 3];
      side = shadow_q[k * ENTRY_W +: 3];
      case (side)
        3'd0:       ;
        3'd1, 3'd3: if (32'(idx) >= N_TB) all_valid = 1'b0;
        3'd2, 3'd4: if (32'(idx) >= N_LR) all_valid = 1'b0;
        default:    all_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_q      <= '0;
      shadow_q   <= '0;
      cnt_q      <= '0;
      cfg_out    <= '0;
      cfg_commit <= 1'b0;
      cfg_err    <= 1'b0;
      err_code   <= 2'b00;
`ifdef CFG_CRC_EN
      crc_q      <= '0;
      crc_rx_q   <= '0;
      crc_cnt_q  <= '0;
`endif
    end else begin
      cfg_commit <= 1'b0;
      if (cfg_abort) begin
        win_q <= '0;
        if (state_q != StIdle) begin
          state_q  <= StIdle;
          shadow_q <= '0;
          cnt_q    <= '0;
          cfg_err  <= 1'b1;
          err_code <= 2'b11;
`ifdef CFG_CRC_EN
          crc_q     <= '0;
          crc_rx_q  <= '0;
          crc_cnt_q <= '0;
`endif
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              if ({win_q[6:0], cfg_bit} == SYNC) begin
                state_q <= StLoad;
                win_q   <= '0;
              end else begin
                win_q <= {win_q[6:0], cfg_bit};
              end
            end
          end
          StLoad: begin
            if (accept) begin
              shadow_q <= {shadow_q[PAY_W-2:0], cfg_bit};
`ifdef CFG_CRC_EN
              crc_q    <= crc_nxt;
`endif
              if (cnt_q == CNT_W'(PAY_W - 1)) begin
                cnt_q <= '0;
`ifdef CFG_CRC_EN
                state_q <= StCrc;
`else
                state_q <= StCheck;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
`ifdef CFG_CRC_EN
          StCrc: begin
            if (accept) begin
              crc_rx_q  <= {crc_rx_q[6:0], cfg_bit};
              crc_cnt_q <= crc_cnt_q + 1'b1;
              if (crc_cnt_q == 3'd7) state_q <= StCheck;
            end
          end
`endif
          StCheck: begin
            state_q <= StIdle;
            if (!all_valid) begin
              cfg_err  <= 1'b1;
              err_code <= 2'b01;
`ifdef CFG_CRC_EN
            end else if (crc_q != crc_rx_q) begin
              cfg_err  <= 1'b1;
              err_code <= 2'b10;
`endif
            end else begin
              cfg_out    <= shadow_q;
              cfg_commit <= 1'b1;
              cfg_err    <= 1'b0;
              err_code   <= 2'b00;
            end
`ifdef CFG_CRC_EN
            crc_q     <= '0;
            crc_rx_q  <= '0;
            crc_cnt_q <= '0;
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_config_loader.sv
// Directed self-checking bench for sm_config_loader; sends CRC bytes when CFG_CRC_EN is defined.
module tb_sm_config_loader;

  localparam int PAY_W = 108;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_bit = 1'b0;
  logic             cfg_abort = 1'b0;
  logic             cfg_ready;
  logic [PAY_W-1:0] cfg_out;
  logic             cfg_commit;
  logic             cfg_busy;
  logic             cfg_err;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;
  bit gaps = 1'b0;
`ifdef CFG_CRC_EN
  bit crc_flip = 1'b0;
`endif

  logic [PAY_W-1:0] p2, p3, p4;

  sm_config_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .cfg_abort  (cfg_abort),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PAY_W-1:0] got,
                       input logic [PAY_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        cfg_valid = 1'b0;
        cfg_bit   = 1'($urandom % 2);
        tick();
      end
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

`ifdef CFG_CRC_EN
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  task automatic send_frame(input logic [PAY_W-1:0] p);
`ifdef CFG_CRC_EN
    logic [7:0] c;
    c = 8'h00;
`endif
    send_byte(8'hA5);
    for (int i = PAY_W - 1; i >= 0; i--) begin
      send_bit(p[i]);
`ifdef CFG_CRC_EN
      c = crc_step(c, p[i]);
`endif
    end
`ifdef CFG_CRC_EN
    if (crc_flip) c[0] = ~c[0];
    send_byte(c);
`endif
  endtask

  // Called right after the last frame bit was accepted
  task automatic expect_commit(input string tag, input logic [PAY_W-1:0] exp);
    check({tag, "_pre_commit"}, PAY_W'(cfg_commit), PAY_W'(0));
    check({tag, "_check_ready"}, PAY_W'(cfg_ready), PAY_W'(0));
    tick();
    check({tag, "_commit"}, PAY_W'(cfg_commit), PAY_W'(1));
    check({tag, "_out"}, cfg_out, exp);
    check({tag, "_err"}, PAY_W'({cfg_err, err_code}), PAY_W'(0));
    tick();
    check({tag, "_pulse_end"}, PAY_W'(cfg_commit), PAY_W'(0));
    check({tag, "_idle"}, PAY_W'({cfg_busy, cfg_ready}), PAY_W'(2'b01));
  endtask

  task automatic expect_reject(input string tag, input logic [PAY_W-1:0] keep,
                               input logic [1:0] code);
    tick();
    check({tag, "_no_commit"}, PAY_W'(cfg_commit), PAY_W'(0));
    check({tag, "_out_kept"}, cfg_out, keep);
    check({tag, "_err"}, PAY_W'({cfg_err, err_code}), PAY_W'({1'b1, code}));
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", cfg_out, '0);
    check("rst_ready", PAY_W'(cfg_ready), PAY_W'(1));
    check("rst_busy", PAY_W'(cfg_busy), PAY_W'(0));
    check("rst_err", PAY_W'({cfg_err, err_code}), PAY_W'(0));
    check("rst_commit", PAY_W'(cfg_commit), PAY_W'(0));
    rst_n = 1'b1;
    tick();

    // Good frame, entry0 = idx 2 / side 3
    p2 = '0;
    p2[5:0] = 6'b010_011;
    send_frame(p2);
    expect_commit("good1", p2);

    // Out-of-range entries: left idx 4, side 7, top idx 5, side 5
    p3 = '0;
    p3[65:60] = 6'b100_010;
    send_frame(p3);
    expect_reject("bad_lr_idx", p2, 2'b01);
    p3 = '0;
    p3[23:18] = 6'b000_111;
    send_frame(p3);
    expect_reject("bad_side7", p2, 2'b01);
    p3 = '0;
    p3[11:6] = 6'b101_001;
    send_frame(p3);
    expect_reject("bad_tb_idx", p2, 2'b01);
    p3 = '0;
    p3[107:102] = 6'b111_101;
    send_frame(p3);
    expect_reject("bad_side5", p2, 2'b01);

    // Every entry at its largest legal index for its side
    p4 = '0;
    for (int k = 0; k < 18; k++) begin
      case (k % 5)
        0:       p4[k*6 +: 6] = {3'd7, 3'd0};
        1, 3:    p4[k*6 +: 6] = {3'd4, 3'(k % 5)};
        default: p4[k*6 +: 6] = {3'd3, 3'(k % 5)};
      endcase
    end

    // Noise before sync must not be loaded
    send_byte(8'h5A);
    send_byte(8'hA4);
    check("noise_idle", PAY_W'(cfg_busy), PAY_W'(0));
    send_frame(p4);
    expect_commit("noise_frame", p4);

    send_frame(p2);
    expect_commit("good2", p2);
    gaps = 1'b1;
    send_frame(p4);
    gaps = 1'b0;
    expect_commit("gappy", p4);

    // Abort after 50 payload bits, with a same-cycle bit
    send_byte(8'hA5);
    for (int i = PAY_W - 1; i >= PAY_W - 50; i--) send_bit(p2[i]);
    check("pre_abort_busy", PAY_W'(cfg_busy), PAY_W'(1));
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    check("abort_idle", PAY_W'(cfg_busy), PAY_W'(0));
    check("abort_err", PAY_W'({cfg_err, err_code}), PAY_W'(3'b111));
    check("abort_out", cfg_out, p4);
    check("abort_commit", PAY_W'(cfg_commit), PAY_W'(0));
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("idle_abort_flags", PAY_W'({cfg_err, err_code}), PAY_W'(3'b111));
    send_frame(p2);
    expect_commit("after_abort", p2);

`ifdef CFG_CRC_EN
    crc_flip = 1'b1;
    send_frame(p4);
    crc_flip = 1'b0;
    expect_reject("crc_bad", p2, 2'b10);
`endif

    // Asynchronous reset mid-load, with error flag set
    p3 = '0;
    p3[65:60] = 6'b100_010;
    send_frame(p3);
    expect_reject("pre_rst_bad", p2, 2'b01);
    send_byte(8'hA5);
    for (int i = PAY_W - 1; i >= PAY_W - 30; i--) send_bit(p4[i]);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out", cfg_out, '0);
    check("arst_err", PAY_W'({cfg_err, err_code}), PAY_W'(0));
    check("arst_busy", PAY_W'(cfg_busy), PAY_W'(0));
    check("arst_ready", PAY_W'(cfg_ready), PAY_W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send_frame(p4);
    expect_commit("post_rst", p4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
